// File: rtl/sample_expand.sv
// Expands narrow ADC/truncated samples into the wide two's-complement datapath
// format and buffers them in a small valid/ready FIFO.
module sample_expand #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 22,
    parameter int SHIFT      = 10,
    parameter int OFFSET_BIN = 0,
    parameter int MID_FILL   = 0,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LW-1:0]    level
);

    localparam logic [OUT_W-1:0] MID_MASK =
        (MID_FILL != 0 && SHIFT > 0) ? (OUT_W'(1) << (SHIFT - 1)) : '0;

    logic [IN_W-1:0]  s;
    logic [OUT_W-1:0] conv;

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push, pop;

    always_comb begin
        s = in_data;
        if (OFFSET_BIN != 0) begin
            s[IN_W-1] = ~in_data[IN_W-1];
        end
        conv = (OUT_W'($signed(s)) << SHIFT) | MID_MASK;
    end

    // in_ready looks only at stored occupancy, so a pop never frees a slot
    // in the same cycle; a full FIFO refuses the push and the source retries.
    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is intentionally not reset; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= conv;
        end
    end

endmodule

// File: tb/tb_sample_expand.sv
// Self-checking bench for sample_expand: three parameter variants driven in
// lockstep, checked against a sample-queue reference model.
module tb_sample_expand;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_def, in_ready_mid, in_ready_off;
    logic        out_valid_def, out_valid_mid, out_valid_off;
    logic [21:0] out_data_def, out_data_mid, out_data_off;
    logic [2:0]  level_def, level_mid, level_off;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] model_q[$];

    typedef struct {
        logic [7:0]  din;
        logic [21:0] exp_def;
        logic [21:0] exp_mid;
        logic [21:0] exp_off;
    } vec_t;

    vec_t table_v[5];

    always #5 clk = ~clk;

    sample_expand #(.OFFSET_BIN(0), .MID_FILL(0)) dut_def (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_def), .out_data(out_data_def), .out_valid(out_valid_def),
        .out_ready(out_ready), .level(level_def)
    );

    sample_expand #(.OFFSET_BIN(0), .MID_FILL(1)) dut_mid (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_mid), .out_data(out_data_mid), .out_valid(out_valid_mid),
        .out_ready(out_ready), .level(level_mid)
    );

    sample_expand #(.OFFSET_BIN(1), .MID_FILL(0)) dut_off (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_off), .out_data(out_data_off), .out_valid(out_valid_off),
        .out_ready(out_ready), .level(level_off)
    );

    // Sample value times 2^10, plus half an LSB when mid-filling, taken modulo 2^22.
    function automatic logic [21:0] expand_model(logic [7:0] smp, bit offset, bit mid);
        int v;
        logic [31:0] t;
        if (offset) v = int'(smp) - 128;
        else        v = (int'(smp) >= 128) ? int'(smp) - 256 : int'(smp);
        v = v * 1024 + (mid ? 512 : 0);
        t = v;
        return t[21:0];
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(logic v, logic [7:0] d, logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    // One clock: predict handshakes from the model occupancy, then compare
    // everything visible at the following falling edge.
    task automatic cycle();
        bit push, pop;
        push = in_valid && (model_q.size() != DEPTH);
        pop  = out_ready && (model_q.size() != 0);
        @(posedge clk);
        if (pop)  void'(model_q.pop_front());
        if (push) model_q.push_back(in_data);
        @(negedge clk);
        checkOutput("level", 32'(level_def), 32'(model_q.size()));
        checkOutput("in_ready", 32'(in_ready_def), 32'(model_q.size() != DEPTH));
        checkOutput("out_valid", 32'(out_valid_def), 32'(model_q.size() != 0));
        checkOutput("out_valid_mid", 32'(out_valid_mid), 32'(model_q.size() != 0));
        checkOutput("out_valid_off", 32'(out_valid_off), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            checkOutput("data_def", 32'(out_data_def), 32'(expand_model(model_q[0], 0, 0)));
            checkOutput("data_mid", 32'(out_data_mid), 32'(expand_model(model_q[0], 0, 1)));
            checkOutput("data_off", 32'(out_data_off), 32'(expand_model(model_q[0], 1, 0)));
        end
    endtask

    initial begin
        table_v[0] = '{8'h7F, 22'h01FC00, 22'h01FE00, 22'h3FFC00};
        table_v[1] = '{8'h80, 22'h3E0000, 22'h3E0200, 22'h000000};
        table_v[2] = '{8'h01, 22'h000400, 22'h000600, 22'h3E0400};
        table_v[3] = '{8'hFF, 22'h3FFC00, 22'h3FFE00, 22'h01FC00};
        table_v[4] = '{8'h00, 22'h000000, 22'h000200, 22'h3E0000};

        reset = 1'b1;
        applyStimulus(0, 8'h00, 0);
        @(negedge clk);
        checkOutput("reset_level", 32'(level_def), 0);
        checkOutput("reset_out_valid", 32'(out_valid_def), 0);
        checkOutput("reset_in_ready", 32'(in_ready_def), 1);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] conversion table");
        foreach (table_v[i]) begin
            applyStimulus(1, table_v[i].din, 1);
            cycle();
            checkOutput("tbl_def", 32'(out_data_def), 32'(table_v[i].exp_def));
            checkOutput("tbl_mid", 32'(out_data_mid), 32'(table_v[i].exp_mid));
            checkOutput("tbl_off", 32'(out_data_off), 32'(table_v[i].exp_off));
        end
        applyStimulus(0, 8'h00, 1);
        cycle();
        checkOutput("tbl_drained", 32'(out_valid_def), 0);

        $display("[TB] stall with five pushes");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'(8'h10 + i), 0);
            cycle();
        end
        checkOutput("full_level", 32'(level_def), 4);
        checkOutput("full_in_ready", 32'(in_ready_def), 0);
        applyStimulus(1, 8'h14, 0);
        repeat (3) cycle();
        checkOutput("stall_head", 32'(out_data_def), 32'h004000);
        applyStimulus(1, 8'h14, 1);
        cycle();
        checkOutput("refused_level", 32'(level_def), 3);
        cycle();
        applyStimulus(0, 8'h00, 1);
        for (int i = 0; i < 10 && model_q.size() != 0; i++) cycle();
        checkOutput("stall_drained", 32'(out_valid_def), 0);

        $display("[TB] full FIFO with both sides active");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'($urandom), 0);
            cycle();
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 8'($urandom), 1);
            cycle();
        end
        applyStimulus(0, 8'h00, 1);
        for (int i = 0; i < 10 && model_q.size() != 0; i++) cycle();

        $display("[TB] reset mid-burst");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'($urandom), 0);
            cycle();
        end
        checkOutput("pre_reset_level", 32'(level_def), 3);
        reset = 1'b1;
        #1;
        checkOutput("async_level", 32'(level_def), 0);
        checkOutput("async_out_valid", 32'(out_valid_def), 0);
        checkOutput("async_in_ready", 32'(in_ready_def), 1);
        model_q.delete();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1, 8'h02, 1);
        cycle();
        checkOutput("post_reset_data", 32'(out_data_def), 32'h000800);
        applyStimulus(0, 8'h00, 1);
        cycle();
        checkOutput("post_reset_empty", 32'(out_valid_def), 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sample_expand.md
# sample_expand

Converts 8-bit truncated/ADC samples back into the 22-bit two's-complement fixed-point format used by the datapath. It is the inverse of the 22→8 truncation stage: sign-extends the sample, re-scales it by a fixed left shift, and optionally fills the discarded LSBs with the mid-point. It sits at the datapath input, behind a small FIFO with a valid/ready handshake on both sides, so a bursty sample source can feed the filter core without losing data.

## Interface
- IN_W, 8: input sample width.
- OUT_W, 22: output word width; IN_W + SHIFT ≤ OUT_W is required.
- SHIFT, 10: left shift applied after sign extension (weight of input LSB = 2^SHIFT).
- OFFSET_BIN, 0: 1 means input is offset-binary; the MSB is inverted before conversion.
- MID_FILL, 0: 1 means the lower SHIFT bits are filled with 1<<(SHIFT-1) instead of zeros.
- DEPTH, 4: FIFO depth, power of two ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  IN_W  sample to expand.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample this cycle.
- out_data  output  OUT_W  expanded fixed-point word at FIFO head.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer takes out_data this cycle.
- level  output  clog2(DEPTH)+1  number of words held.

## Operation
- Conversion, combinational on the input side, result written into the FIFO:
  - s = OFFSET_BIN ? {~in_data[IN_W-1], in_data[IN_W-2:0]} : in_data.
  - out = sign-extend(s) to OUT_W, shifted left by SHIFT. Bit OUT_W-1 equals the sign of s.
  - If MID_FILL=1, bit SHIFT-1 is set and bits SHIFT-2..0 are 0.
  - There is no overflow: the range is exact by the width constraint.
- FIFO: DEPTH entries, write pointer, read pointer, and an occupancy counter `level`. Pointers wrap modulo DEPTH.
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
- in_ready = (level != DEPTH). It depends only on registered state and never combinationally on out_ready.
- out_valid = (level != 0). out_data = mem[rd_ptr]. out_data is not registered separately; it comes from storage.
- Push and pop in the same cycle (level between 1 and DEPTH-1): level is unchanged and both pointers advance.
- When full, in_ready is 0 even if a pop occurs that cycle. The push is refused and the source retries next cycle.
- When empty, a pop is not possible, and there is no bypass.
- While out_valid=1 and out_ready=0, out_data must hold stable.

## Timing
- Reset (asynchronous, immediate): level=0, pointers=0, out_valid=0, in_ready=1.
  - out_data reads mem[0]; storage is not cleared, and contents are don't-care while out_valid=0.
- Latency: a sample accepted at rising edge N appears with out_valid=1 after edge N, so it is available for consumption in cycle N+1. That is 1 cycle minimum through an empty FIFO.
- Throughput: 1 word per cycle sustained when level is between 1 and DEPTH-1 and both sides are active.
- Reset asserted mid-burst: all queued words are discarded and out_valid drops asynchronously. No word is emitted twice after reset release.
- Ordering is strictly FIFO; no word is lost or duplicated.

## Test plan
- Defaults (SHIFT=10, OFFSET_BIN=0, MID_FILL=0); push 8'h7F, 8'h80, 8'h01, 8'hFF with out_ready=1 → outputs 22'h01FC00, 22'h3E0000, 22'h000400, 22'h3FFC00, each one cycle after acceptance.
- MID_FILL=1; push 8'h01 then 8'h00 → 22'h000600, then 22'h000200.
- OFFSET_BIN=1; push 8'h00, 8'h80, 8'hFF → 22'h3E0000, 22'h000000, 22'h01FC00.
- out_ready=0; push 5 words → after 4 pushes level=4 and in_ready=0, and the 5th push is held off. Release out_ready → all 5 words arrive in order, and out_data stays stable while stalled.
- Full FIFO with in_valid=1 and out_ready=1 → each cycle pops 1 word, the push is refused while full, and accepted the next cycle. level alternates 4/3 with no loss.
- Assert reset mid-burst with level=3 → out_valid=0, level=0, and in_ready=1 immediately. The next pushed 8'h02 emerges as 22'h000800.
